counter_report_top: RTL and testbench
=====================================

// Module: counter_report_top
// PURPOSE
//  Parametrised successor to the board-level up-counter top. Prescaled up/down counter with pause,
//  multiplexed hex 7-segment display of the low NUM_DIGITS nibbles, and a UART reporter that
//  frames every new count value as bytes (MSB first) plus 0x0A for the existing uart_transmitter.
// PARAMETERS
//  WIDTH       32          counter width in bits (>=4)
//  TICK_DIV    100000000   clk cycles per count step (>=2)
//  SCAN_DIV    100000      clk cycles per display digit (>=2)
//  NUM_DIGITS  4           number of 7-seg digits scanned (1..8, NUM_DIGITS*4 <= WIDTH)
// PORTS
//  clk               in   1            system clock, all logic on rising edge
//  i_reset_n         in   1            asynchronous active-low reset
//  i_up              in   1            count direction: 1 up, 0 down
//  i_pause           in   1            1 = hold count (prescaler keeps running)
//  i_uart_busy       in   1            uart_transmitter busy flag
//  o_count           out  WIDTH        current count
//  o_led             out  1            count LSB
//  o_segment_enable  out  [0:6]        segments a..g, active-low
//  o_display_enable  out  [0:NUM_DIGITS-1] digit select, active-low one-hot
//  o_dot_enable      out  1            decimal point, active-low
//  o_uart_data       out  8            byte to transmit
//  o_uart_start      out  1            transmit request, held until acknowledged
//  o_overrun         out  1            sticky: a count value was not reported
// BEHAVIOUR
//  Reset (async assert, sync release): count=0, prescaler=0, digit idx=0, FSM=IDLE, o_uart_start=0,
//   o_uart_data=0, o_overrun=0, o_segment_enable/o_display_enable/o_dot_enable all 1 (blank).
//  Prescaler: counts 0..TICK_DIV-1, wraps; tick = (prescaler==TICK_DIV-1).
//  Count: on tick and !i_pause, count <= count+1 (i_up=1) or count-1 (i_up=0), modulo 2^WIDTH
//   (max+1 -> 0, 0-1 -> all ones). i_up/i_pause sampled on the tick cycle only.
//  Update event = tick && !i_pause; count change visible on o_count the cycle after the tick.
//  Reporter: BYTES = ceil(WIDTH/8); frame = BYTES bytes of zero-extended count, MSB byte first, then 0x0A.
//   States: IDLE, START, ACK, DRAIN.
//   IDLE: on update event, snapshot new count value into shadow reg, idx=BYTES, go START.
//   START: o_uart_start=1, o_uart_data=current byte (idx==0 -> 0x0A); stay until i_uart_busy=1 -> ACK.
//   ACK: o_uart_start=0; wait i_uart_busy=0 -> DRAIN.
//   DRAIN: if idx==0 -> IDLE else idx-1 -> START (one idle cycle between bytes).
//   Update event while not IDLE: sample dropped, o_overrun<=1 (cleared only by reset).
//   o_uart_data stable for the whole time o_uart_start=1.
//  Display: scan counter 0..SCAN_DIV-1; at wrap, digit idx advances, NUM_DIGITS-1 -> 0.
//   Digit k shows nibble count[4k+3:4k], hex decode 0-F (standard a..g), 0 = segment lit.
//   Outputs registered: pattern for idx appears one cycle after idx changes; exactly one digit low.
//   o_dot_enable = 0 only while digit 0 active and i_pause=1 (pause indicator), else 1.
//  Simultaneous: tick on the cycle FSM returns to IDLE is dropped (FSM not yet IDLE) -> overrun.
//  Reset mid-frame: o_uart_start drops immediately; no partial-frame resume.
// TESTING (WIDTH=12, TICK_DIV=4, SCAN_DIV=2, NUM_DIGITS=3 unless noted)
//  1 Reset then 12 clk, i_up=1, UART model acks instantly -> o_count 0,1,2,3 on steps every 4 clk.
//  2 Count 0, i_up=0, one tick -> o_count=0xFFF; then i_up=1 at 0xFFF -> 0x000 (wrap both ways).
//  3 Count 0x0A5 reported with busy model (1 clk ack, 20 clk busy) -> bytes 0x00,0xA5,0x0A in order,
//    o_uart_start held until busy high, o_overrun stays 0 with TICK_DIV=200.
//  4 TICK_DIV=4, UART busy 20 clk/byte -> dropped samples, o_overrun=1 and stays 1 until i_reset_n=0.
//  5 Count 0x3C7: digits 0,1,2 show 7,C,3 (o_segment_enable 0001111,0110001,0000110), one-hot low
//    o_display_enable, i_pause=1 -> count frozen, dot low only on digit 0.
//  6 Assert i_reset_n=0 mid-byte (o_uart_start=1) -> o_uart_start=0 and all display outputs 1
//    asynchronously; after release first frame starts on the first update event.

Source files
------------

// File: rtl/counter_report_top.sv
// counter_report_top
//   Prescaled up/down counter with pause, a multiplexed hex 7-segment display
//   of the low NUM_DIGITS nibbles, and a UART reporter that frames every new
//   count value as ceil(WIDTH/8) bytes (MSB first) followed by 0x0A.
//
// Ports
//   clk               system clock, rising edge
//   i_reset_n         asynchronous active-low reset
//   i_up              count direction (1 up, 0 down), sampled on tick only
//   i_pause           hold count on tick (prescaler keeps running)
//   i_uart_busy       busy flag from the uart_transmitter
//   o_count           current count
//   o_led             count LSB
//   o_segment_enable  segments a..g, active-low ([0] = a)
//   o_display_enable  digit select, active-low one-hot ([k] = digit k)
//   o_dot_enable      decimal point, active-low (pause indicator on digit 0)
//   o_uart_data       byte being offered to the transmitter
//   o_uart_start      transmit request, held until busy is seen
//   o_overrun         sticky: a count value was dropped unreported
//
// Reset asserts asynchronously; its release is expected to be synchronous to
// clk (the board reset block already provides that).
module counter_report_top #(
  parameter int WIDTH      = 32,
  parameter int TICK_DIV   = 100000000,
  parameter int SCAN_DIV   = 100000,
  parameter int NUM_DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  i_reset_n,
  input  logic                  i_up,
  input  logic                  i_pause,
  input  logic                  i_uart_busy,
  output logic [WIDTH-1:0]      o_count,
  output logic                  o_led,
  output logic [0:6]            o_segment_enable,
  output logic [0:NUM_DIGITS-1] o_display_enable,
  output logic                  o_dot_enable,
  output logic [7:0]            o_uart_data,
  output logic                  o_uart_start,
  output logic                  o_overrun
);

  localparam int BYTES = (WIDTH + 7) / 8;
  localparam int PW    = $clog2(TICK_DIV);
  localparam int SW    = $clog2(SCAN_DIV);
  localparam int DW    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int IW    = $clog2(BYTES + 1);

  typedef enum logic [1:0] {IDLE, START, ACK, DRAIN} state_t;

  // ---------------- prescaler / counter ----------------
  logic [PW-1:0]    presc_q;
  logic [WIDTH-1:0] count_q, count_step;
  logic             tick, upd;

  assign tick       = (presc_q == PW'(TICK_DIV - 1));
  assign upd        = tick & ~i_pause;
  assign count_step = i_up ? count_q + WIDTH'(1) : count_q - WIDTH'(1);

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      presc_q <= '0;
      count_q <= '0;
    end else begin
      presc_q <= tick ? '0 : presc_q + PW'(1);
      if (upd) count_q <= count_step;
    end
  end

  assign o_count = count_q;
  assign o_led   = count_q[0];

  // ---------------- UART reporter ----------------
  state_t               state_q, state_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [BYTES*8-1:0]   shadow_q, shadow_d;
  logic                 ovr_q, ovr_d;
  logic [7:0]           byte_sel;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    // Any update that finds the reporter away from IDLE is lost, including
    // the one landing on the DRAIN->IDLE cycle.
    ovr_d    = ovr_q | (upd & (state_q != IDLE));
    case (state_q)
      IDLE: if (upd) begin
        shadow_d = (BYTES*8)'(count_step);
        idx_d    = IW'(BYTES);
        state_d  = START;
      end
      START: if (i_uart_busy) state_d = ACK;
      ACK:   if (!i_uart_busy) state_d = DRAIN;
      DRAIN: begin
        if (idx_q == '0) state_d = IDLE;
        else begin
          idx_d   = idx_q - IW'(1);
          state_d = START;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // idx counts down BYTES..1 over the value bytes, 0 selects the terminator.
  always_comb begin
    byte_sel = 8'h0A;
    for (int j = 1; j <= BYTES; j++)
      if (idx_q == IW'(j)) byte_sel = shadow_q[8*(j-1) +: 8];
  end

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      shadow_q <= '0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      ovr_q    <= ovr_d;
    end
  end

  // Decoded from state so an async reset drops the request immediately.
  assign o_uart_start = (state_q == START);
  assign o_uart_data  = (state_q == START) ? byte_sel : 8'h00;
  assign o_overrun    = ovr_q;

  // ---------------- 7-segment scan ----------------
  function automatic logic [0:6] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'b0000001;  4'h1: hex7 = 7'b1001111;
      4'h2: hex7 = 7'b0010010;  4'h3: hex7 = 7'b0000110;
      4'h4: hex7 = 7'b1001100;  4'h5: hex7 = 7'b0100100;
      4'h6: hex7 = 7'b0100000;  4'h7: hex7 = 7'b0001111;
      4'h8: hex7 = 7'b0000000;  4'h9: hex7 = 7'b0000100;
      4'hA: hex7 = 7'b0001000;  4'hB: hex7 = 7'b1100000;
      4'hC: hex7 = 7'b0110001;  4'hD: hex7 = 7'b1000010;
      4'hE: hex7 = 7'b0110000;  default: hex7 = 7'b0111000;
    endcase
  endfunction

  logic [SW-1:0]           scan_q;
  logic [DW-1:0]           dig_q;
  logic                    scan_wrap;
  logic [3:0]              nib;
  logic [0:6]              seg_q, seg_d;
  logic [0:NUM_DIGITS-1]   disp_q, disp_d;
  logic                    dot_q, dot_d;

  assign scan_wrap = (scan_q == SW'(SCAN_DIV - 1));

  always_comb begin
    nib    = 4'h0;
    disp_d = '1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (dig_q == DW'(k)) begin
        nib       = count_q[4*k +: 4];
        disp_d[k] = 1'b0;
      end
    end
    seg_d = hex7(nib);
    dot_d = ~((dig_q == '0) & i_pause);
  end

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      scan_q <= '0;
      dig_q  <= '0;
      seg_q  <= '1;
      disp_q <= '1;
      dot_q  <= 1'b1;
    end else begin
      scan_q <= scan_wrap ? '0 : scan_q + SW'(1);
      if (scan_wrap)
        dig_q <= (dig_q == DW'(NUM_DIGITS - 1)) ? '0 : dig_q + DW'(1);
      seg_q  <= seg_d;
      disp_q <= disp_d;
      dot_q  <= dot_d;
    end
  end

  assign o_segment_enable = seg_q;
  assign o_display_enable = disp_q;
  assign o_dot_enable     = dot_q;

endmodule

// File: tb/tb_counter_report_top.sv
// Bench for counter_report_top (WIDTH=12, TICK_DIV=4, SCAN_DIV=2, NUM_DIGITS=3).
// Model: the count advances on every TICK_DIV-th clock after reset release if
// not paused; every such value is queued as "to be reported". The bench plays
// the UART transmitter and matches completed frames against that queue.
module tb_counter_report_top;
  localparam int W = 12, TD = 4, SD = 2, ND = 3;

  logic clk = 1'b0, rst_n = 1'b1, up = 1'b1, pause = 1'b0, busy = 1'b0;
  logic [W-1:0]  count;
  logic          led, dot, ustart, ovr;
  logic [0:6]    seg;
  logic [0:ND-1] disp;
  logic [7:0]    udata;

  counter_report_top #(.WIDTH(W), .TICK_DIV(TD), .SCAN_DIV(SD), .NUM_DIGITS(ND)) dut (
    .clk(clk), .i_reset_n(rst_n), .i_up(up), .i_pause(pause), .i_uart_busy(busy),
    .o_count(count), .o_led(led), .o_segment_enable(seg), .o_display_enable(disp),
    .o_dot_enable(dot), .o_uart_data(udata), .o_uart_start(ustart), .o_overrun(ovr));

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int k = 0, busy_cnt = 0, wait_cnt = 0, ack_dly = 0, busy_len = 1, nframes = 0;
  bit strict = 0, rand_ack = 0, prev_start = 0;
  logic [7:0]   prev_data = 8'h00;
  logic [W-1:0] cnt_m = '0, last_val = '0;
  logic [W-1:0] upd_q[$];
  logic [7:0]   rx[$];
  logic [0:6]   seg_tab [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                 7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                 7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                                 7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic frame_check();
    logic [15:0] val;
    logic [31:0] e;
    bit found;
    int skipped;
    val = {rx[0], rx[1]};
    check("frame_term", 32'(rx[2]), 32'h0A);
    nframes++;
    last_val = val[W-1:0];
    if (strict) begin
      if (upd_q.size() > 0) e = 32'(upd_q.pop_front());
      else e = 32'hBAD0;
      check("frame_value", 32'(val), e);
    end else begin
      // Reported values must be an in-order subsequence of the updates.
      found = 0; skipped = 0;
      while (!found && upd_q.size() > 0) begin
        if (upd_q[0] == val[W-1:0] && val[15:W] == '0) found = 1;
        else skipped++;
        void'(upd_q.pop_front());
      end
      check("frame_in_sequence", 32'(found), 32'd1);
      if (skipped > 0) check("overrun_on_drop", 32'(ovr), 32'd1);
    end
    rx.delete();
  endtask

  // Transmitter model: acks after ack_dly samples of start, busy for busy_len clocks.
  task automatic uart();
    if (prev_start && ustart)  check("data_stable", 32'(udata), 32'(prev_data));
    if (prev_start && !ustart) check("start_until_busy", 32'(busy), 32'd1);
    prev_start = ustart;
    prev_data  = udata;
    if (busy_cnt > 0) begin
      busy_cnt--;
      if (busy_cnt == 0) busy = 1'b0;
    end else if (ustart) begin
      if (wait_cnt >= ack_dly) begin
        rx.push_back(udata);
        busy = 1'b1; busy_cnt = busy_len; wait_cnt = 0;
        if (rand_ack) ack_dly = $urandom_range(0, 3);
        if (rx.size() == 3) frame_check();
      end else wait_cnt++;
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
    k++;
    if (k % TD == 0 && !pause) begin
      cnt_m = up ? cnt_m + W'(1) : cnt_m - W'(1);
      upd_q.push_back(cnt_m);
    end
    check("count", 32'(count), 32'(cnt_m));
    check("led", 32'(led), 32'(cnt_m[0]));
    uart();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; busy = 1'b0;
    #1;
    check("rst_count", 32'(count), 32'd0);
    check("rst_seg",   32'(seg),   32'h7F);
    check("rst_disp",  32'(disp),  32'h7);
    check("rst_dot",   32'(dot),   32'd1);
    check("rst_start", 32'(ustart), 32'd0);
    check("rst_data",  32'(udata), 32'd0);
    check("rst_ovr",   32'(ovr),   32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    k = 0; cnt_m = '0; upd_q.delete(); rx.delete();
    busy_cnt = 0; wait_cnt = 0; prev_start = 0; nframes = 0;
  endtask

  initial begin
    int dk, got;
    logic [ND-1:0] seen;

    // 1: basic up count, instant ack
    do_reset();
    repeat (12) step();
    check("t1_count12", 32'(count), 32'd3);

    // 2: wrap both ways
    do_reset();
    up = 1'b0;
    repeat (4) step();
    check("wrap_down", 32'(count), 32'hFFF);
    up = 1'b1;
    repeat (4) step();
    check("wrap_up", 32'(count), 32'h000);

    // 3: one update every 96 clocks, slow UART, every frame must arrive intact
    do_reset();
    strict = 1; rand_ack = 1; ack_dly = 1; busy_len = 20; up = 1'b1;
    for (int n = 0; n < 165*96 + 90; n++) begin
      pause = ((k + 1) % 96 != 0);
      step();
    end
    check("t3_last_frame", 32'(last_val), 32'h0A5);
    check("t3_nframes", 32'(nframes), 32'd165);
    check("t3_no_overrun", 32'(ovr), 32'd0);

    // 4: random direction/pause with a slow UART -> drops and sticky overrun
    do_reset();
    strict = 0; busy_len = 20; rand_ack = 1;
    for (int n = 0; n < 600; n++) begin
      up    = 1'($urandom_range(0, 1));
      pause = ($urandom_range(0, 3) == 0);
      step();
    end
    check("t4_overrun_set", 32'(ovr), 32'd1);
    pause = 1'b1;
    repeat (150) step();
    check("t4_overrun_sticky", 32'(ovr), 32'd1);

    // 5: display of 0x3C7 with pause held
    do_reset();
    busy_len = 1; rand_ack = 0; ack_dly = 0; up = 1'b1; pause = 1'b0;
    for (int n = 0; n < 4000; n++) begin
      pause = (cnt_m == 12'h3C7);
      step();
    end
    check("t5_reach", 32'(count), 32'h3C7);
    seen = '0;
    for (int n = 0; n < 12; n++) begin
      step();
      dk = 0;
      for (int j = 0; j < ND; j++) if (disp[j] == 1'b0) dk = j;
      check("t5_onehot", 32'($countones(~disp)), 32'd1);
      check("t5_seg", 32'(seg), 32'(seg_tab[(cnt_m >> (4*dk)) & 12'hF]));
      check("t5_dot", 32'(dot), (dk == 0) ? 32'd0 : 32'd1);
      seen[dk] = 1'b1;
    end
    check("t5_all_digits", 32'(seen), 32'h7);
    pause = 1'b0;
    step();
    repeat (6) begin
      step();
      check("t5_dot_off", 32'(dot), 32'd1);
    end

    // 6: reset while a byte is being offered
    busy_len = 20; ack_dly = 3; rand_ack = 0; strict = 0;
    got = 0;
    for (int n = 0; n < 200 && got == 0; n++) begin
      step();
      got = int'(ustart);
    end
    check("t6_wait_start", 32'(got), 32'd1);
    do_reset();
    strict = 1; up = 1'b1;
    for (int n = 0; n < 120; n++) begin
      pause = ((k + 1) != 8);
      step();
    end
    check("t6_one_frame", 32'(nframes), 32'd1);
    check("t6_value", 32'(last_val), 32'd1);
    check("t6_no_overrun", 32'(ovr), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
